// File: rtl/l15_req_arbiter_if.sv
// Request-side bundle between the L1 requesters, the arbiter and the L1.5.
// The slave modport is the arbiter's view; master is the requester/L1.5 view.
interface l15_req_arbiter_if #(
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 40
);
    localparam int PortIdW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [NumPorts-1:0]           req_valid_i;
    logic [NumPorts-1:0]           req_ready_o;
    logic [NumPorts*5-1:0]         req_type_i;
    logic [NumPorts*AddrWidth-1:0] req_addr_i;
    logic [NumPorts*3-1:0]         req_size_i;
    logic [NumPorts-1:0]           req_nc_i;
    logic [NumPorts*64-1:0]        req_data_i;

    logic                          l15_val_o;
    logic [4:0]                    l15_rqtype_o;
    logic [AddrWidth-1:0]          l15_address_o;
    logic [2:0]                    l15_size_o;
    logic                          l15_nc_o;
    logic [63:0]                   l15_data_o;
    logic [PortIdW-1:0]            l15_portid_o;
    logic                          l15_header_ack_i;

    logic                          rsp_valid_i;
    logic [PortIdW-1:0]            rsp_portid_i;

    modport slave (
        input  req_valid_i, req_type_i, req_addr_i, req_size_i, req_nc_i, req_data_i,
        output req_ready_o,
        output l15_val_o, l15_rqtype_o, l15_address_o, l15_size_o, l15_nc_o,
        output l15_data_o, l15_portid_o,
        input  l15_header_ack_i,
        input  rsp_valid_i, rsp_portid_i
    );

    modport master (
        output req_valid_i, req_type_i, req_addr_i, req_size_i, req_nc_i, req_data_i,
        input  req_ready_o,
        input  l15_val_o, l15_rqtype_o, l15_address_o, l15_size_o, l15_nc_o,
        input  l15_data_o, l15_portid_o,
        output l15_header_ack_i,
        output rsp_valid_i, rsp_portid_i
    );
endinterface

// File: rtl/l15_req_arbiter.sv
// L1.5 request arbiter/serializer: merges I$, D$ read, D$ write and AMO
// requesters into one registered L1.5 request stream. Fixed priority with
// starvation promotion, per-port outstanding limit, sticky protocol error.
module l15_req_arbiter #(
    parameter int NumPorts       = 4,
    parameter int AddrWidth      = 40,
    parameter int MaxOutstanding = 4,
    parameter int StarveTh       = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    l15_req_arbiter_if.slave bus,
    output logic             busy_o,
    output logic             err_o
);

    localparam int PortIdW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CntW    = $clog2(MaxOutstanding + 1);
    localparam int StvW    = 4;

    localparam logic [CntW-1:0]    MaxOut      = CntW'(MaxOutstanding);
    localparam logic [StvW-1:0]    StvTh       = StvW'(StarveTh);
    localparam logic [PortIdW:0]   NumPortsExt = (PortIdW + 1)'(NumPorts);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [4:0]           type_q, type_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [2:0]           size_q, size_d;
    logic                 nc_q, nc_d;
    logic [63:0]          data_q, data_d;
    logic [PortIdW-1:0]   portid_q, portid_d;

    logic [CntW-1:0]      outst_q  [NumPorts];
    logic [CntW-1:0]      outst_d  [NumPorts];
    logic [StvW-1:0]      starve_q [NumPorts];
    logic [StvW-1:0]      starve_d [NumPorts];
    logic                 err_q, err_d;

    logic [NumPorts-1:0]  eligible;
    logic [NumPorts-1:0]  starved;
    logic [NumPorts-1:0]  cand;
    logic [NumPorts-1:0]  grant_oh;
    logic [PortIdW-1:0]   grant_idx;
    logic [NumPorts-1:0]  inc_vec;
    logic [NumPorts-1:0]  dec_vec;
    logic                 decision;
    logic                 accept;
    logic                 busy;
    logic [PortIdW:0]     rsp_pid_ext;

    logic [4:0]           sel_type;
    logic [AddrWidth-1:0] sel_addr;
    logic [2:0]           sel_size;
    logic                 sel_nc;
    logic [63:0]          sel_data;

    // Starvation counter increment, saturating at the promotion threshold.
    function automatic logic [StvW-1:0] sat_inc_starve(input logic [StvW-1:0] v);
        return (v >= StvTh) ? v : v + StvW'(1);
    endfunction

    // A decision is made whenever the output slot is free or being freed now.
    assign decision    = (state_q == IDLE) || bus.l15_header_ack_i;
    assign accept      = decision && (|eligible);
    assign cand        = (|starved) ? starved : eligible;
    assign rsp_pid_ext = {1'b0, bus.rsp_portid_i};

    // Eligibility and starvation status per port.
    always_comb begin
        eligible = '0;
        starved  = '0;
        for (int p = 0; p < NumPorts; p++) begin
            eligible[p] = bus.req_valid_i[p] && (outst_q[p] < MaxOut);
            starved[p]  = eligible[p] && (starve_q[p] == StvTh);
        end
    end

    // Lowest-index candidate wins; starved ports form the candidate set when any exist.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int p = NumPorts - 1; p >= 0; p--) begin
            if (cand[p]) begin
                grant_oh    = '0;
                grant_oh[p] = 1'b1;
                grant_idx   = PortIdW'(p);
            end
        end
    end

    // Payload mux of the granted port.
    always_comb begin
        sel_type = '0;
        sel_addr = '0;
        sel_size = '0;
        sel_nc   = 1'b0;
        sel_data = '0;
        for (int p = 0; p < NumPorts; p++) begin
            if (grant_oh[p]) begin
                sel_type = bus.req_type_i[p*5 +: 5];
                sel_addr = bus.req_addr_i[p*AddrWidth +: AddrWidth];
                sel_size = bus.req_size_i[p*3 +: 3];
                sel_nc   = bus.req_nc_i[p];
                sel_data = bus.req_data_i[p*64 +: 64];
            end
        end
    end

    // FSM next state and payload capture; payload only moves on accept.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        addr_d   = addr_q;
        size_d   = size_q;
        nc_d     = nc_q;
        data_d   = data_q;
        portid_d = portid_q;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (bus.l15_header_ack_i) state_d = accept ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            type_d   = sel_type;
            addr_d   = sel_addr;
            size_d   = sel_size;
            nc_d     = sel_nc;
            data_d   = sel_data;
            portid_d = grant_idx;
        end
    end

    // Per-port accept and completion strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int p = 0; p < NumPorts; p++) begin
            inc_vec[p] = accept && grant_oh[p];
            dec_vec[p] = bus.rsp_valid_i && (bus.rsp_portid_i == PortIdW'(p));
        end
    end

    // Outstanding counters and protocol error detection.
    always_comb begin
        err_d = err_q;
        for (int p = 0; p < NumPorts; p++) begin
            outst_d[p] = outst_q[p];
            if (inc_vec[p] && !dec_vec[p]) begin
                outst_d[p] = outst_q[p] + CntW'(1);
            end else if (dec_vec[p] && !inc_vec[p]) begin
                if (outst_q[p] == '0) begin
                    err_d = 1'b1;
                end else begin
                    outst_d[p] = outst_q[p] - CntW'(1);
                end
            end
        end
        if (bus.rsp_valid_i && (rsp_pid_ext >= NumPortsExt)) begin
            err_d = 1'b1;
        end
    end

    // Starvation counters: count lost decisions, clear on grant or dropped valid.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            starve_d[p] = starve_q[p];
            if (!bus.req_valid_i[p]) begin
                starve_d[p] = '0;
            end else if (decision) begin
                if (grant_oh[p]) begin
                    starve_d[p] = '0;
                end else if (eligible[p]) begin
                    starve_d[p] = sat_inc_starve(starve_q[p]);
                end
            end
        end
    end

    // Busy while anything is in flight or presented.
    always_comb begin
        busy = (state_q == SEND);
        for (int p = 0; p < NumPorts; p++) begin
            if (outst_q[p] != '0) busy = 1'b1;
        end
    end

    // FSM state and registered L1.5 payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            type_q   <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            nc_q     <= 1'b0;
            data_q   <= '0;
            portid_q <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            nc_q     <= nc_d;
            data_q   <= data_d;
            portid_q <= portid_d;
        end
    end

    // Per-port outstanding/starvation counters and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumPorts; p++) begin
                outst_q[p]  <= '0;
                starve_q[p] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                outst_q[p]  <= outst_d[p];
                starve_q[p] <= starve_d[p];
            end
            err_q <= err_d;
        end
    end

    // Ready is forced low while reset is asserted so no accept is signalled.
    assign bus.req_ready_o   = (rst_ni && accept) ? grant_oh : '0;
    assign bus.l15_val_o     = (state_q == SEND);
    assign bus.l15_rqtype_o  = type_q;
    assign bus.l15_address_o = addr_q;
    assign bus.l15_size_o    = size_q;
    assign bus.l15_nc_o      = nc_q;
    assign bus.l15_data_o    = data_q;
    assign bus.l15_portid_o  = portid_q;
    assign busy_o            = busy;
    assign err_o             = err_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Testbench for l15_req_arbiter: scoreboard of expected L1.5 requests plus
// directed cycle checks of handshake, priority, starvation, limits and reset.
module tb_l15_req_arbiter;

    localparam int NP = 4;
    localparam int AW = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    // Core clock.
    always #5 clk = ~clk;

    l15_req_arbiter_if #(.NumPorts(NP), .AddrWidth(AW)) bus ();

    l15_req_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .MaxOutstanding(4), .StarveTh(8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus),
        .busy_o(busy),
        .err_o (err)
    );

    typedef struct {
        logic [1:0]  pid;
        logic [39:0] addr;
        logic [4:0]  typ;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [39:0] a, input logic [4:0] t);
        bus.req_addr_i[p*AW +: AW] = a;
        bus.req_type_i[p*5 +: 5]   = t;
        bus.req_size_i[p*3 +: 3]   = 3'(p);
        bus.req_nc_i[p]            = p[0];
        bus.req_data_i[p*64 +: 64] = {24'hA5A5A5, a};
    endtask

    task automatic push(input int p, input logic [39:0] a, input logic [4:0] t);
        exp_t e;
        e.pid  = 2'(p);
        e.addr = a;
        e.typ  = t;
        e.data = {24'hA5A5A5, a};
        sb.push_back(e);
    endtask

    // Scoreboard: every accepted L1.5 header is compared against the next expected request.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.l15_val_o && bus.l15_header_ack_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_portid", 64'(bus.l15_portid_o), 64'(e.pid));
                chk("sb_addr", 64'(bus.l15_address_o), 64'(e.addr));
                chk("sb_type", 64'(bus.l15_rqtype_o), 64'(e.typ));
                chk("sb_data", bus.l15_data_o, e.data);
            end
        end
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_rdy;
        logic [39:0] a1, a0, a2, a3, b;
        int          k;

        a1 = 40'h80_0000_0040;
        a0 = 40'h10_0000_1000;
        a2 = 40'h20_0000_2000;
        a3 = 40'h30_0000_3000;
        b  = 40'h44_0000_0000;

        bus.req_valid_i      = '0;
        bus.req_type_i       = '0;
        bus.req_addr_i       = '0;
        bus.req_size_i       = '0;
        bus.req_nc_i         = '0;
        bus.req_data_i       = '0;
        bus.l15_header_ack_i = 1'b0;
        bus.rsp_valid_i      = 1'b0;
        bus.rsp_portid_i     = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_val", 64'(bus.l15_val_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", 64'(bus.l15_address_o), 64'd0);
        chk("rst_ready", 64'(bus.req_ready_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single request on port 1
        set_req(1, a1, 5'd0);
        bus.req_valid_i = 4'b0010;
        #1;
        chk("t1_ready", 64'(bus.req_ready_o), 64'b0010);
        push(1, a1, 5'd0);
        tick();
        bus.req_valid_i = '0;
        #1;
        chk("t1_val", 64'(bus.l15_val_o), 64'd1);
        chk("t1_addr", 64'(bus.l15_address_o), 64'(a1));
        chk("t1_pid", 64'(bus.l15_portid_o), 64'd1);
        tick();
        chk("t1_hold", 64'(bus.l15_val_o), 64'd1);
        tick();
        bus.l15_header_ack_i = 1'b1;
        chk("t1_val_c3", 64'(bus.l15_val_o), 64'd1);
        tick();
        bus.l15_header_ack_i = 1'b0;
        chk("t1_val_drop", 64'(bus.l15_val_o), 64'd0);
        chk("t1_busy_outst", 64'(busy), 64'd1);
        bus.rsp_valid_i  = 1'b1;
        bus.rsp_portid_i = 2'd1;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t1_busy_clear", 64'(busy), 64'd0);

        // Priority and back-to-back
        set_req(0, a0, 5'd1);
        set_req(2, a2, 5'd9);
        bus.req_valid_i      = 4'b0101;
        bus.l15_header_ack_i = 1'b1;
        #1;
        chk("t2_ready0", 64'(bus.req_ready_o), 64'b0001);
        push(0, a0, 5'd1);
        push(2, a2, 5'd9);
        tick();
        bus.req_valid_i = 4'b0100;
        #1;
        chk("t2_ready2", 64'(bus.req_ready_o), 64'b0100);
        chk("t2_val1", 64'(bus.l15_val_o), 64'd1);
        chk("t2_pid1", 64'(bus.l15_portid_o), 64'd0);
        tick();
        bus.req_valid_i = '0;
        #1;
        chk("t2_val2", 64'(bus.l15_val_o), 64'd1);
        chk("t2_pid2", 64'(bus.l15_portid_o), 64'd2);
        chk("t2_ready_none", 64'(bus.req_ready_o), 64'd0);
        tick();
        bus.l15_header_ack_i = 1'b0;
        chk("t2_val3", 64'(bus.l15_val_o), 64'd0);
        bus.rsp_valid_i  = 1'b1;
        bus.rsp_portid_i = 2'd0;
        tick();
        bus.rsp_portid_i = 2'd2;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t2_busy", 64'(busy), 64'd0);

        // Starvation promotion of port 3 behind a continuously valid port 0
        set_req(0, a0, 5'd4);
        set_req(3, a3, 5'd6);
        for (int c = 0; c < 12; c++) begin
            bus.req_valid_i      = {(c <= 8), 1'b0, 1'b0, (c <= 10)};
            bus.l15_header_ack_i = 1'b1;
            bus.rsp_valid_i      = bus.l15_val_o;
            bus.rsp_portid_i     = bus.l15_portid_o;
            #1;
            exp_rdy = (c == 8) ? 4'b1000 : ((c <= 10) ? 4'b0001 : 4'b0000);
            chk($sformatf("t3_ready_c%0d", c), 64'(bus.req_ready_o), 64'(exp_rdy));
            if (exp_rdy == 4'b1000) push(3, a3, 5'd6);
            else if (exp_rdy == 4'b0001) push(0, a0, 5'd4);
            tick();
        end
        bus.l15_header_ack_i = 1'b0;
        bus.rsp_valid_i      = 1'b0;
        #1;
        chk("t3_val_end", 64'(bus.l15_val_o), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_err", 64'(err), 64'd0);
        tick();

        // Outstanding limit on port 2
        k = 0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid_i = 4'b0100;
            set_req(2, b + 40'(k * 256), 5'd5);
            bus.l15_header_ack_i = 1'b1;
            bus.rsp_valid_i      = (c == 6);
            bus.rsp_portid_i     = 2'd2;
            #1;
            exp_rdy = (c < 4 || c == 7) ? 4'b0100 : 4'b0000;
            chk($sformatf("t4_ready_c%0d", c), 64'(bus.req_ready_o), 64'(exp_rdy));
            if (exp_rdy != 4'b0000) begin
                push(2, b + 40'(k * 256), 5'd5);
                k++;
            end
            tick();
        end
        bus.req_valid_i = '0;
        bus.rsp_valid_i = 1'b0;
        #1;
        chk("t4_val5", 64'(bus.l15_val_o), 64'd1);
        chk("t4_addr5", 64'(bus.l15_address_o), 64'(b + 40'(4 * 256)));
        chk("t4_pid5", 64'(bus.l15_portid_o), 64'd2);
        tick();
        bus.l15_header_ack_i = 1'b0;
        bus.rsp_valid_i      = 1'b1;
        bus.rsp_portid_i     = 2'd2;
        repeat (4) tick();
        bus.rsp_valid_i = 1'b0;
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_err", 64'(err), 64'd0);

        // Stall with ack low, then asynchronous reset mid-stall
        set_req(1, a1 + 40'h8, 5'd3);
        bus.req_valid_i = 4'b0010;
        #1;
        chk("t5_ready", 64'(bus.req_ready_o), 64'b0010);
        tick();
        set_req(0, a0 + 40'h10, 5'd7);
        bus.req_valid_i = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_val", 64'(bus.l15_val_o), 64'd1);
            chk("t5_addr", 64'(bus.l15_address_o), 64'(a1 + 40'h8));
            chk("t5_pid", 64'(bus.l15_portid_o), 64'd1);
            chk("t5_type", 64'(bus.l15_rqtype_o), 64'd3);
            chk("t5_ready0", 64'(bus.req_ready_o), 64'd0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_val", 64'(bus.l15_val_o), 64'd0);
        chk("t5_async_addr", 64'(bus.l15_address_o), 64'd0);
        bus.req_valid_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_val_after", 64'(bus.l15_val_o), 64'd0);
        chk("t5_err", 64'(err), 64'd0);

        // Completion for a port with nothing outstanding
        bus.rsp_valid_i  = 1'b1;
        bus.rsp_portid_i = 2'd0;
        tick();
        bus.rsp_valid_i = 1'b0;
        chk("t6_err_set", 64'(err), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("t6_err_sticky", 64'(err), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_reset", 64'(err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
- Multi-port request arbiter and serializer placed directly in front of the OpenPiton L1.5 request interface.
- Merges I$ miss, D$ miss-read, D$ write-buffer and AMO request channels into one registered L1.5 request stream.
- Honours the L1.5 valid/header_ack handshake and tracks outstanding transactions per port.
- Applies fixed priority, where port 0 is highest, plus starvation promotion so lower ports are never locked out.

Parameters:
- NumPorts, 4: number of requester ports (0=I$, 1=D$ read, 2=D$ write, 3=AMO).
- AddrWidth, 40: physical request address width.
- MaxOutstanding, 4: maximum in-flight requests per port.
- StarveTh, 8: decision cycles a port may lose before it is promoted.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NumPorts  per-port request valid.
- req_ready_o  out  NumPorts  per-port accept, one-hot or zero.
- req_type_i  in  NumPorts*5  per-port L1.5 rqtype.
- req_addr_i  in  NumPorts*AddrWidth  per-port address.
- req_size_i  in  NumPorts*3  per-port L1.5 size code.
- req_nc_i  in  NumPorts  per-port non-cacheable flag.
- req_data_i  in  NumPorts*64  per-port store/AMO data.
- l15_val_o  out  1  request valid to L1.5.
- l15_rqtype_o  out  5  request type.
- l15_address_o  out  AddrWidth  request address.
- l15_size_o  out  3  request size.
- l15_nc_o  out  1  non-cacheable flag.
- l15_data_o  out  64  request data.
- l15_portid_o  out  $clog2(NumPorts)  originating port, used by the return path.
- l15_header_ack_i  in  1  L1.5 accepted the current request.
- rsp_valid_i  in  1  a transaction completed.
- rsp_portid_i  in  $clog2(NumPorts)  port that owns the completion.
- busy_o  out  1  high when any outstanding count is non-zero or l15_val_o is high.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (asynchronous, active-low): every output and internal register goes to 0. This covers l15_val_o, all payload registers, outstanding counters, starvation counters and err_o. FSM enters IDLE. Reset asserted mid-request drops l15_val_o immediately; no replay.
- FSM states: IDLE and SEND.
  - IDLE, eligible port exists: go to SEND.
  - SEND, l15_header_ack_i=1 and eligible port exists: stay in SEND with the new request.
  - SEND, l15_header_ack_i=1 and no eligible port: go to IDLE.
  - SEND, l15_header_ack_i=0: hold. The payload must not change while l15_val_o=1 and ack=0.
- Decision cycle: any cycle in IDLE, or a SEND cycle with l15_header_ack_i=1.
- Eligibility: port p is eligible when req_valid_i[p]=1 and outstanding[p] < MaxOutstanding.
- Grant selection (combinational):
  - If any eligible port is starved (starve[p]==StarveTh), grant the lowest-index starved eligible port.
  - Otherwise grant the lowest-index eligible port.
- Accept: in a decision cycle with a grant, req_ready_o[grant]=1 in the same cycle. Payload and portid are registered, and l15_val_o=1 from the next cycle. Latency is 1 cycle from accept to l15_val_o.
- Back-to-back requests: ack in cycle N with another eligible port means the next request is valid in N+1 with no bubble.
- req_ready_o is 0 in every non-decision cycle. Requesters must hold valid and payload until ready.
- Outstanding counters (3 bits, $clog2(MaxOutstanding+1)):
  - Increment on accept; decrement on rsp_valid_i for rsp_portid_i.
  - Simultaneous increment and decrement on the same port: unchanged.
  - Decrement at 0: counter stays 0 and err_o is set.
- Starvation counters (4 bits):
  - In a decision cycle, each eligible port that is not granted increments, saturating at StarveTh.
  - Cleared when the port is granted or when req_valid_i[p]=0.
  - Ineligible ports that are valid hold their value.
- err_o is also set if rsp_portid_i >= NumPorts while rsp_valid_i=1. err_o clears only on reset.

Test Plan:
- Single request: port 1 valid, addr 0x80_0000_0040, type 0 → ready[1] in cycle 0. l15_val_o=1 in cycle 1 with addr 0x80_0000_0040 and portid 1. Ack in cycle 3 → l15_val_o=0 in cycle 4.
- Priority and back-to-back: ports 0 and 2 both valid, ack always 1 → port 0 granted in cycle 0, port 2 in cycle 1, with l15_val_o high in cycles 1 and 2.
- Starvation, StarveTh=8: port 0 continuously valid and port 3 valid, ack always 1 → port 3 granted at the 9th decision cycle, then port 0 resumes.
- Outstanding limit: port 2 issues 4 requests with no rsp → 5th request not accepted and ready[2]=0. Then rsp_valid_i with portid 2 → 5th request accepted in the following decision cycle.
- Stall and reset: l15_header_ack_i held 0 for 10 cycles → payload stable. Assert rst_ni low mid-stall → l15_val_o=0 asynchronously; after release, counters=0 and busy_o=0.
- Error: rsp_valid_i with portid 0 while outstanding[0]=0 → err_o=1 the next cycle and stays 1 until reset.
